// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, loader and Data_Memory signals around the arbiter.
interface dmem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ldr_gnt, ldr_rdata, ldr_rvalid, mem_addr, mem_wdata, mem_we, mem_re
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, ldr_gnt, ldr_rdata, ldr_rvalid, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port Data_Memory between the CPU load/store path and a loader,
// round-robin on ties with a bounded loader burst while the CPU waits.
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  dmem_arbiter_if.master bus
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic [1:0] {IDLE, CPU_OWN, LDR_OWN} state_t;
  state_t          r_state, w_next;
  logic            r_last_cpu;
  logic [CW-1:0]   r_burst, w_burst_nxt;
  logic            r_rvalid;
  logic [$bits(bus.ldr_rdata)-1:0] r_rdata;
  logic            w_cap, w_cpu_own, w_ldr_own, w_ldr_gnt, w_ldr_rd;
  assign w_cap     = r_burst == CW'(MAX_BURST - 1);
  assign w_cpu_own = r_state == CPU_OWN;
  assign w_ldr_own = r_state == LDR_OWN;
  assign w_ldr_gnt = bus.ldr_req & w_ldr_own;
  assign w_ldr_rd  = w_ldr_gnt & ~bus.ldr_we;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = (bus.cpu_req & (~bus.ldr_req | ~r_last_cpu)) ? CPU_OWN :
                        bus.ldr_req ? LDR_OWN : IDLE;
      CPU_OWN: w_next = bus.ldr_req ? LDR_OWN : bus.cpu_req ? CPU_OWN : IDLE;
      LDR_OWN: w_next = (bus.cpu_req & (w_cap | ~bus.ldr_req)) ? CPU_OWN :
                        bus.ldr_req ? LDR_OWN : IDLE;
      default: w_next = IDLE;
    endcase
    // burst count saturates so a long solo stream hands over immediately once the CPU asks
    w_burst_nxt = (w_ldr_own && w_next == LDR_OWN) ? (w_cap ? r_burst : r_burst + 1'b1) : '0;
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_last_cpu <= 1'b0;
      r_burst    <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state  <= w_next;
      r_burst  <= w_burst_nxt;
      r_rvalid <= w_ldr_rd;
      if (w_next != IDLE) r_last_cpu <= w_next == CPU_OWN;
      if (w_ldr_rd) r_rdata <= bus.mem_rdata;
    end
  end
  assign bus.mem_addr   = w_cpu_own ? bus.cpu_addr  : w_ldr_own ? bus.ldr_addr  : '0;
  assign bus.mem_wdata  = w_cpu_own ? bus.cpu_wdata : w_ldr_own ? bus.ldr_wdata : '0;
  assign bus.mem_we     = (w_cpu_own & bus.cpu_req & bus.cpu_we) | (w_ldr_own & bus.ldr_req & bus.ldr_we);
  assign bus.mem_re     = (w_cpu_own & bus.cpu_req & ~bus.cpu_we) | (w_ldr_own & bus.ldr_req & ~bus.ldr_we);
  assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_own;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ldr_gnt    = w_ldr_gnt;
  assign bus.ldr_rdata  = r_rdata;
  assign bus.ldr_rvalid = r_rvalid;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed steps against a behavioural Data_Memory, read data checked via scoreboard queues.
module tb_dmem_arbiter;
  logic clk, reset;
  int   n_checks = 0, n_errors = 0;
  logic [31:0] mem [256];
  logic [31:0] ldr_q[$], cpu_q[$];
  dmem_arbiter_if bus ();
  dmem_arbiter #(.MAX_BURST(4)) dut (.i_clk(clk), .i_reset(reset), .bus(bus));
  assign bus.mem_rdata = mem[8'(bus.mem_addr)];
  always @(posedge clk) if (bus.mem_we) mem[8'(bus.mem_addr)] <= bus.mem_wdata;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (bus.ldr_rvalid) begin
      chk("ldr_q_nonempty", 32'(ldr_q.size() != 0), 32'd1);
      if (ldr_q.size() != 0) chk("ldr_rdata", bus.ldr_rdata, ldr_q.pop_front());
    end
    if (bus.cpu_req && !bus.cpu_we && !bus.cpu_stall) begin
      chk("cpu_q_nonempty", 32'(cpu_q.size() != 0), 32'd1);
      if (cpu_q.size() != 0) chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
    end
  end
  task automatic clear_in();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
  endtask
  task automatic ldr_op(input logic we, input logic [31:0] a, input logic [31:0] d, input int exp_wait);
    int w = 0;
    @(negedge clk);
    bus.ldr_req = 1; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
    if (!we) ldr_q.push_back(d);
    #1;
    while (!bus.ldr_gnt && w < 8) begin
      w++;
      @(negedge clk);
      #1;
    end
    chk("ldr_wait", 32'(w), 32'(exp_wait));
    @(negedge clk);
    bus.ldr_req = 0; bus.ldr_we = 0;
  endtask
  task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d, input int exp_stall);
    int s = 0;
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    if (!we) cpu_q.push_back(d);
    #1;
    while (bus.cpu_stall && s < 8) begin
      s++;
      @(negedge clk);
      #1;
    end
    chk("cpu_stall_cycles", 32'(s), 32'(exp_stall));
    @(negedge clk);
    bus.cpu_req = 0; bus.cpu_we = 0;
  endtask
  initial begin
    int k, n_gnt;
    reset = 0;
    clear_in();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_re", 32'(bus.mem_re), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_ldr_gnt", 32'(bus.ldr_gnt), 0);
    chk("rst_ldr_rvalid", 32'(bus.ldr_rvalid), 0);
    chk("rst_ldr_rdata", bus.ldr_rdata, 0);
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 0);
    @(negedge clk) reset = 1;
    // tie straight after reset: CPU first, loader granted in the third cycle
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h11;
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h44; bus.ldr_wdata = 32'h22;
    #1;
    chk("tie_c1_stall", 32'(bus.cpu_stall), 1);
    chk("tie_c1_gnt", 32'(bus.ldr_gnt), 0);
    chk("tie_c1_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    #1;
    chk("tie_c2_stall", 32'(bus.cpu_stall), 0);
    chk("tie_c2_gnt", 32'(bus.ldr_gnt), 0);
    chk("tie_c2_addr", bus.mem_addr, 32'h40);
    chk("tie_c2_we", 32'(bus.mem_we), 1);
    @(negedge clk);
    bus.cpu_req = 0;
    #1;
    chk("tie_c3_gnt", 32'(bus.ldr_gnt), 1);
    chk("tie_c3_addr", bus.mem_addr, 32'h44);
    chk("tie_c3_wdata", bus.mem_wdata, 32'h22);
    @(negedge clk);
    bus.ldr_req = 0;
    #1;
    chk("drop_req_we", 32'(bus.mem_we), 0);
    chk("drop_req_re", 32'(bus.mem_re), 0);
    chk("mem40", mem[8'h40], 32'h11);
    chk("mem44", mem[8'h44], 32'h22);
    // CPU load from IDLE: one stall cycle
    ldr_op(1, 32'h10, 32'hDEADBEEF, 1);
    cpu_op(0, 32'h10, 32'hDEADBEEF, 1);
    // loader write then read back
    ldr_op(1, 32'h20, 32'h1234, 1);
    ldr_op(0, 32'h20, 32'h1234, 1);
    #1;
    chk("rvalid_pulse", 32'(bus.ldr_rvalid), 1);
    @(negedge clk);
    #1;
    chk("rvalid_clear", 32'(bus.ldr_rvalid), 0);
    // CPU store then load while owning
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h8; bus.cpu_wdata = 32'hA5;
    #1;
    chk("st_stall", 32'(bus.cpu_stall), 1);
    @(negedge clk);
    #1;
    chk("st_own_stall", 32'(bus.cpu_stall), 0);
    chk("st_we", 32'(bus.mem_we), 1);
    @(negedge clk);
    bus.cpu_we = 0;
    cpu_q.push_back(32'hA5);
    #1;
    chk("ld_own_stall", 32'(bus.cpu_stall), 0);
    chk("ld_re", 32'(bus.mem_re), 1);
    @(negedge clk);
    bus.cpu_req = 0;
    // burst cap: CPU raised on the first loader grant
    @(negedge clk);
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h50; bus.ldr_wdata = 32'h99;
    #1;
    chk("burst_idle_gnt", 32'(bus.ldr_gnt), 0);
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h44;
    cpu_q.push_back(32'h22);
    k = 0;
    n_gnt = 0;
    #1;
    while (bus.cpu_stall && k < 10) begin
      n_gnt += int'(bus.ldr_gnt);
      k++;
      @(negedge clk);
      #1;
    end
    chk("burst_gnts", 32'(n_gnt), 32'd4);
    chk("burst_cpu_wait", 32'(k), 32'd4);
    chk("burst_cpu_cycle_gnt", 32'(bus.ldr_gnt), 0);
    @(negedge clk);
    bus.cpu_req = 0;
    #1;
    chk("burst_resume_gnt", 32'(bus.ldr_gnt), 1);
    @(negedge clk);
    bus.ldr_req = 0;
    // reset asserted during a loader write
    ldr_op(1, 32'h30, 32'h77, 1);
    @(negedge clk);
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 32'h30; bus.ldr_wdata = 32'h55;
    @(negedge clk);
    #1;
    chk("midw_we_before", 32'(bus.mem_we), 1);
    #2;
    reset = 0;
    #1;
    chk("midw_we", 32'(bus.mem_we), 0);
    chk("midw_gnt", 32'(bus.ldr_gnt), 0);
    chk("midw_addr", bus.mem_addr, 0);
    chk("midw_wdata", bus.mem_wdata, 0);
    chk("midw_rvalid", 32'(bus.ldr_rvalid), 0);
    chk("midw_rdata", bus.ldr_rdata, 0);
    @(negedge clk);
    chk("midw_mem30", mem[8'h30], 32'h77);
    bus.ldr_req = 0; bus.ldr_we = 0;
    reset = 1;
    ldr_op(0, 32'h30, 32'h77, 1);
    repeat (2) @(negedge clk);
    chk("ldr_q_drained", 32'(ldr_q.size()), 0);
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
